// File: rtl/restoring_divider_32bit_pkg.sv
// Shared types and constants for the sequential restoring divider.
package restoring_divider_32bit_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned Iter = 32;
  localparam int unsigned CntW = 5;
  localparam logic [31:0] Div0Quotient = 32'hFFFF_FFFF;

endpackage

// File: rtl/restoring_divider_32bit_if.sv
// Request/result bundle for the restoring divider.
interface restoring_divider_32bit_if;

  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/restoring_divider_32bit_sub.sv
// 32-bit ripple-borrow subtractor: D = X - Y - b_in. B0..B6 are the borrows out of nibbles 0..6.
module ripple_carry_subtractor_32bit (
  input  logic [31:0] X,
  input  logic [31:0] Y,
  input  logic        b_in,
  output logic [31:0] D,
  output logic        b_out,
  output logic        B0,
  output logic        B1,
  output logic        B2,
  output logic        B3,
  output logic        B4,
  output logic        B5,
  output logic        B6
);

  logic [32:0] borrow;

  // Bit-serial full-subtractor chain.
  always_comb begin
    borrow    = '0;
    D         = '0;
    borrow[0] = b_in;
    for (int i = 0; i < 32; i++) begin
      D[i]          = X[i] ^ Y[i] ^ borrow[i];
      borrow[i + 1] = (~X[i] & Y[i]) | (~(X[i] ^ Y[i]) & borrow[i]);
    end
  end

  assign b_out = borrow[32];
  assign B0    = borrow[4];
  assign B1    = borrow[8];
  assign B2    = borrow[12];
  assign B3    = borrow[16];
  assign B4    = borrow[20];
  assign B5    = borrow[24];
  assign B6    = borrow[28];

endmodule

// File: rtl/restoring_divider_32bit.sv
// Sequential unsigned 32/32 restoring divider, one quotient bit per clock.
module restoring_divider_32bit
  import restoring_divider_32bit_pkg::*;
(
  input logic                             clk,
  input logic                             rst,
  restoring_divider_32bit_if.slave        div_if
);

  state_e            state_q, state_d;
  logic [31:0]       q_q, q_d;
  logic [31:0]       r_q, r_d;
  logic [31:0]       dvsr_q, dvsr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              div0_q, div0_d;

  logic [31:0]       r_shift;
  logic [31:0]       diff;
  logic              borrow;
  logic [6:0]        unused_borrow;
  logic              accept;

  // Partial remainder shifted left with the next dividend bit brought in.
  assign r_shift = {r_q[30:0], q_q[31]};

  ripple_carry_subtractor_32bit u_sub (
    .X     (r_shift),
    .Y     (dvsr_q),
    .b_in  (1'b0),
    .D     (diff),
    .b_out (borrow),
    .B0    (unused_borrow[0]),
    .B1    (unused_borrow[1]),
    .B2    (unused_borrow[2]),
    .B3    (unused_borrow[3]),
    .B4    (unused_borrow[4]),
    .B5    (unused_borrow[5]),
    .B6    (unused_borrow[6])
  );

  // A start is only taken when not iterating; the DONE cycle counts as idle.
  assign accept = div_if.start && (state_q != StCalc);

  // Next-state logic for FSM, counter and shift registers.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    div0_d  = div0_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          q_d    = div_if.dividend;
          r_d    = '0;
          dvsr_d = div_if.divisor;
          cnt_d  = '0;
          div0_d = 1'b0;
          if (div_if.divisor != '0) begin
            state_d = StCalc;
          end else begin
            state_d = StDone;
            q_d     = Div0Quotient;
            r_d     = div_if.dividend;
            div0_d  = 1'b1;
          end
        end
      end
      StCalc: begin
        // r_q[31] set means the 33-bit shifted value exceeds any divisor; low 32 bits of D exact.
        if (r_q[31] || !borrow) begin
          r_d = diff;
          q_d = {q_q[30:0], 1'b1};
        end else begin
          r_d = r_shift;
          q_d = {q_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(Iter - 1)) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      q_q     <= '0;
      r_q     <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      div0_q  <= div0_d;
    end
  end

  assign div_if.busy        = (state_q == StCalc);
  assign div_if.done        = (state_q == StDone);
  assign div_if.quotient    = q_q;
  assign div_if.remainder   = r_q;
  assign div_if.div_by_zero = div0_q;

endmodule

// File: tb/tb_restoring_divider_32bit.sv
// Directed bench for the restoring divider.
module tb_restoring_divider_32bit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n;
  int   done_seen;

  restoring_divider_32bit_if div_if ();

  restoring_divider_32bit dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (div_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a request for one edge; returns 1ns after the accepting edge.
  task automatic start_op(input logic [31:0] dd, input logic [31:0] dv);
    div_if.start    = 1'b1;
    div_if.dividend = dd;
    div_if.divisor  = dv;
    @(posedge clk);
    #1;
    div_if.start = 1'b0;
  endtask

  // Count edges until done is seen, bounded at 40.
  task automatic wait_done(output int edges);
    edges = 0;
    while (div_if.done !== 1'b1 && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  initial begin
    div_if.start    = 1'b0;
    div_if.dividend = '0;
    div_if.divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, div_if.busy}, 32'd0);
    check("rst_done", {31'd0, div_if.done}, 32'd0);
    check("rst_div0", {31'd0, div_if.div_by_zero}, 32'd0);
    check("rst_quot", div_if.quotient, 32'd0);
    check("rst_rem", div_if.remainder, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 100 / 7
    start_op(32'd100, 32'd7);
    check("a_busy", {31'd0, div_if.busy}, 32'd1);
    wait_done(n);
    check("a_lat", n, 32'd32);
    check("a_quot", div_if.quotient, 32'd14);
    check("a_rem", div_if.remainder, 32'd2);
    check("a_div0", {31'd0, div_if.div_by_zero}, 32'd0);
    check("a_busy_done", {31'd0, div_if.busy}, 32'd0);
    @(posedge clk);
    #1;
    check("a_done_pulse", {31'd0, div_if.done}, 32'd0);

    // msb=1 path
    start_op(32'hFFFF_FFFF, 32'h8000_0001);
    wait_done(n);
    check("b_lat", n, 32'd32);
    check("b_quot", div_if.quotient, 32'd1);
    check("b_rem", div_if.remainder, 32'h7FFF_FFFE);
    @(posedge clk);
    #1;
    start_op(32'hFFFF_FFFF, 32'd1);
    wait_done(n);
    check("c_quot", div_if.quotient, 32'hFFFF_FFFF);
    check("c_rem", div_if.remainder, 32'd0);
    @(posedge clk);
    #1;

    // Divide by zero, then a normal op clears the flag
    start_op(32'd5, 32'd0);
    check("z_done", {31'd0, div_if.done}, 32'd1);
    check("z_busy", {31'd0, div_if.busy}, 32'd0);
    check("z_quot", div_if.quotient, 32'hFFFF_FFFF);
    check("z_rem", div_if.remainder, 32'd5);
    check("z_div0", {31'd0, div_if.div_by_zero}, 32'd1);
    @(posedge clk);
    #1;
    check("z_done_pulse", {31'd0, div_if.done}, 32'd0);
    check("z_div0_held", {31'd0, div_if.div_by_zero}, 32'd1);
    start_op(32'd9, 32'd3);
    check("d_div0_clr", {31'd0, div_if.div_by_zero}, 32'd0);
    wait_done(n);
    check("d_lat", n, 32'd32);
    check("d_quot", div_if.quotient, 32'd3);
    check("d_rem", div_if.remainder, 32'd0);
    @(posedge clk);
    #1;

    // Start while busy is ignored
    start_op(32'd1000, 32'd10);
    repeat (9) @(posedge clk);
    #1;
    start_op(32'd50, 32'd5);
    check("e_busy", {31'd0, div_if.busy}, 32'd1);
    wait_done(n);
    check("e_lat", n, 32'd22);
    check("e_quot", div_if.quotient, 32'd100);
    check("e_rem", div_if.remainder, 32'd0);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-operation
    start_op(32'd1000, 32'd10);
    repeat (14) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("r_busy", {31'd0, div_if.busy}, 32'd0);
    check("r_done", {31'd0, div_if.done}, 32'd0);
    check("r_quot", div_if.quotient, 32'd0);
    check("r_rem", div_if.remainder, 32'd0);
    #1;
    rst = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (div_if.done === 1'b1) done_seen++;
    end
    check("r_no_done", done_seen, 32'd0);

    // Back-to-back: start held through the DONE cycle; input changes after acceptance ignored
    div_if.start    = 1'b1;
    div_if.dividend = 32'd7;
    div_if.divisor  = 32'd2;
    @(posedge clk);
    #1;
    div_if.dividend = 32'd0;
    div_if.divisor  = 32'd5;
    wait_done(n);
    check("f_lat", n, 32'd32);
    check("f_quot", div_if.quotient, 32'd3);
    check("f_rem", div_if.remainder, 32'd1);
    @(posedge clk);
    #1;
    div_if.start = 1'b0;
    check("g_busy", {31'd0, div_if.busy}, 32'd1);
    wait_done(n);
    check("g_lat", n, 32'd32);
    check("g_quot", div_if.quotient, 32'd0);
    check("g_rem", div_if.remainder, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
